// File: rtl/keypad_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | keypad_ctrl: debounced 4x4 keypad sequencing with two-digit display mux     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module keypad_ctrl #(
  parameter int DEBOUNCE_CYCLES = 60000,
  parameter int MUX_CYCLES      = 12000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [3:0] key_value,
  output logic       scan_hold,
  output logic       new_key,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic [3:0] seg_digit,
  output logic       an_left_n,
  output logic       an_right_n
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MUX_W = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
  localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MUX_W-1:0] c_mux_last = MUX_W'(MUX_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic             new_key_q, new_key_d;
  logic [3:0]       digit_left_q, digit_left_d;
  logic [3:0]       digit_right_q, digit_right_d;
  logic [MUX_W-1:0] mux_cnt_q, mux_cnt_d;
  logic             sel_q, sel_d;  // 0 = left digit driven

  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    cand_d        = cand_q;
    new_key_d     = 1'b0;
    digit_left_d  = digit_left_q;
    digit_right_d = digit_right_q;

    case (state_q)
      IDLE: begin
        if (key_pressed) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
          cand_d   = key_value;
        end
      end
      PRESS_DB: begin
        if (!key_pressed || (key_value != cand_q)) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else if (db_cnt_q == c_db_last) begin
          state_d       = HELD;
          db_cnt_d      = '0;
          new_key_d     = 1'b1;
          digit_left_d  = digit_right_q;
          digit_right_d = cand_q;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!key_pressed) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end
      end
      REL_DB: begin
        // A re-press during release is contact bounce, not a new key.
        if (key_pressed) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt_q == c_db_last) begin
          state_d  = IDLE;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        db_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    mux_cnt_d = mux_cnt_q + MUX_W'(1);
    sel_d     = sel_q;
    if (mux_cnt_q == c_mux_last) begin
      mux_cnt_d = '0;
      sel_d     = ~sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      cand_q        <= '0;
      new_key_q     <= 1'b0;
      digit_left_q  <= '0;
      digit_right_q <= '0;
      mux_cnt_q     <= '0;
      sel_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      cand_q        <= cand_d;
      new_key_q     <= new_key_d;
      digit_left_q  <= digit_left_d;
      digit_right_q <= digit_right_d;
      mux_cnt_q     <= mux_cnt_d;
      sel_q         <= sel_d;
    end
  end

  assign scan_hold   = (state_q != IDLE);
  assign new_key     = new_key_q;
  assign digit_left  = digit_left_q;
  assign digit_right = digit_right_q;
  assign seg_digit   = sel_q ? digit_right_q : digit_left_q;
  assign an_left_n   = sel_q;
  assign an_right_n  = ~sel_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_keypad_ctrl: vector table, directed corner sequences, random vs. model   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_keypad_ctrl;

  localparam int DB  = 4;
  localparam int MUX = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_pressed;
  logic [3:0] key_value;
  logic       scan_hold;
  logic       new_key;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic [3:0] seg_digit;
  logic       an_left_n;
  logic       an_right_n;

  keypad_ctrl #(.DEBOUNCE_CYCLES(DB), .MUX_CYCLES(MUX)) dut (
    .clk(clk), .reset(reset), .key_pressed(key_pressed), .key_value(key_value),
    .scan_hold(scan_hold), .new_key(new_key), .digit_left(digit_left),
    .digit_right(digit_right), .seg_digit(seg_digit),
    .an_left_n(an_left_n), .an_right_n(an_right_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  // Reference model: consecutive-sample counting of press/release runs.
  bit         m_busy, m_held, m_pulse;
  int         m_run, m_rel, m_t;
  logic [3:0] m_cand, m_left, m_right;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_held = 0; m_pulse = 0; m_run = 0; m_rel = 0; m_t = 0;
    m_cand = 4'h0; m_left = 4'h0; m_right = 4'h0;
  endtask

  task automatic model_step(input bit kp, input logic [3:0] kv);
    m_pulse = 0;
    m_t++;
    if (!m_busy) begin
      if (kp) begin m_busy = 1; m_held = 0; m_run = 0; m_cand = kv; end
    end else if (!m_held) begin
      if (!kp || kv != m_cand) m_busy = 0;
      else begin
        m_run++;
        if (m_run == DB) begin
          m_held = 1; m_rel = 0; m_pulse = 1;
          m_left = m_right; m_right = m_cand;
        end
      end
    end else begin
      // a release needs DB+1 consecutive low samples
      if (kp) m_rel = 0;
      else begin
        m_rel++;
        if (m_rel == DB + 1) begin m_busy = 0; m_held = 0; end
      end
    end
  endtask

  task automatic cycle(input bit r, input bit kp, input logic [3:0] kv);
    bit sel;
    reset = r; key_pressed = kp; key_value = kv;
    @(posedge clk);
    if (r) model_reset(); else model_step(kp, kv);
    #1;
    sel = ((m_t / MUX) % 2) == 1;
    if (new_key === 1'b1) n_pulses++;
    check("scan_hold", 32'(scan_hold), 32'(m_busy));
    check("new_key", 32'(new_key), 32'(m_pulse));
    check("digit_left", 32'(digit_left), 32'(m_left));
    check("digit_right", 32'(digit_right), 32'(m_right));
    check("seg_digit", 32'(seg_digit), 32'(sel ? m_right : m_left));
    check("an_left_n", 32'(an_left_n), 32'(sel));
    check("an_right_n", 32'(an_right_n), 32'(!sel));
  endtask

  typedef struct {
    bit         rst;
    bit         kp;
    logic [3:0] kv;
    bit         nk;
    bit         hold;
    logic [3:0] l;
    logic [3:0] r;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(bit rst, bit kp, logic [3:0] kv, bit nk, bit hold,
                              logic [3:0] l, logic [3:0] r);
    vec_t v;
    v.rst = rst; v.kp = kp; v.kv = kv; v.nk = nk; v.hold = hold; v.l = l; v.r = r;
    return v;
  endfunction

  initial begin
    bit         rkp;
    logic [3:0] rkv;
    bit         rr;

    // reset, 3 idle, press A for 10 samples, release 6 samples
    vecs[0] = mk(1, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    for (int i = 1; i <= 3; i++) vecs[i] = mk(0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
    for (int i = 4; i <= 7; i++) vecs[i] = mk(0, 1, 4'hA, 0, 1, 4'h0, 4'h0);
    vecs[8] = mk(0, 1, 4'hA, 1, 1, 4'h0, 4'hA);
    for (int i = 9; i <= 13; i++) vecs[i] = mk(0, 1, 4'hA, 0, 1, 4'h0, 4'hA);
    for (int i = 14; i <= 17; i++) vecs[i] = mk(0, 0, 4'h0, 0, 1, 4'h0, 4'hA);
    vecs[18] = mk(0, 0, 4'h0, 0, 0, 4'h0, 4'hA);
    vecs[19] = mk(0, 0, 4'h0, 0, 0, 4'h0, 4'hA);

    reset = 1'b1; key_pressed = 1'b0; key_value = 4'h0;
    model_reset();

    // idle after reset: anodes alternate, nothing registered
    cycle(1, 0, 4'h0);
    n_pulses = 0;
    for (int i = 0; i < 20; i++) cycle(0, 0, 4'h0);
    check("idle_pulses", 32'(n_pulses), 32'd0);
    check("idle_hold", 32'(scan_hold), 32'd0);

    n_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].rst, vecs[i].kp, vecs[i].kv);
      check("tbl_new_key", 32'(new_key), 32'(vecs[i].nk));
      check("tbl_scan_hold", 32'(scan_hold), 32'(vecs[i].hold));
      check("tbl_left", 32'(digit_left), 32'(vecs[i].l));
      check("tbl_right", 32'(digit_right), 32'(vecs[i].r));
    end
    check("tbl_pulses", 32'(n_pulses), 32'd1);

    // second key shifts the first one left
    for (int i = 0; i < 6; i++) cycle(0, 1, 4'h5);
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'h0);
    check("two_keys_left", 32'(digit_left), 32'hA);
    check("two_keys_right", 32'(digit_right), 32'h5);
    check("two_keys_hold", 32'(scan_hold), 32'd0);

    // press bounce 1,1,0 then a clean run
    n_pulses = 0;
    cycle(0, 1, 4'h9); cycle(0, 1, 4'h9); cycle(0, 0, 4'h9);
    for (int i = 0; i < 4; i++) cycle(0, 1, 4'h9);
    check("bounce_no_early", 32'(n_pulses), 32'd0);
    cycle(0, 1, 4'h9);
    check("bounce_pulse", 32'(n_pulses), 32'd1);
    check("bounce_right", 32'(digit_right), 32'h9);
    check("bounce_left", 32'(digit_left), 32'h5);
    // release bounce returns to held without a new event
    cycle(0, 0, 4'h9); cycle(0, 1, 4'h9); cycle(0, 1, 4'h9); cycle(0, 1, 4'h9);
    check("rel_bounce_hold", 32'(scan_hold), 32'd1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'h0);
    check("rel_bounce_pulses", 32'(n_pulses), 32'd1);
    check("rel_bounce_idle", 32'(scan_hold), 32'd0);

    // value change mid-debounce aborts, then a stable 7 registers
    n_pulses = 0;
    cycle(0, 1, 4'h3); cycle(0, 1, 4'h3); cycle(0, 1, 4'h7);
    check("chg_no_event", 32'(n_pulses), 32'd0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 4'h7);
    check("chg_pulses", 32'(n_pulses), 32'd1);
    check("chg_right", 32'(digit_right), 32'h7);
    check("chg_left", 32'(digit_left), 32'h9);
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'h0);

    // reset during PRESS_DB and during HELD
    n_pulses = 0;
    cycle(0, 1, 4'h2); cycle(0, 1, 4'h2);
    cycle(1, 1, 4'h2);
    check("rst_pdb_hold", 32'(scan_hold), 32'd0);
    check("rst_pdb_nk", 32'(new_key), 32'd0);
    check("rst_pdb_right", 32'(digit_right), 32'h0);
    check("rst_pdb_left", 32'(digit_left), 32'h0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 4'h2);
    check("rst_held_pre", 32'(digit_right), 32'h2);
    cycle(1, 1, 4'h2);
    check("rst_held_hold", 32'(scan_hold), 32'd0);
    check("rst_held_right", 32'(digit_right), 32'h0);
    check("rst_held_nk", 32'(new_key), 32'd0);
    check("rst_pulses", 32'(n_pulses), 32'd1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 4'h0);

    // random key activity against the model
    rkp = 0; rkv = 4'h0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) < 15) rkp = !rkp;
      if ($urandom_range(99) < 8) rkv = 4'($urandom_range(15));
      rr = ($urandom_range(299) == 0);
      cycle(rr, rkp, rkv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
